// File: rtl/mux3_rr_arbiter_pkg.sv
// mux3_arb_pkg: shared types, source ids and select encoding for the 3:1 round-robin arbiter
package mux3_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    typedef logic [1:0] src_id_t;
    localparam src_id_t SRC0         = 2'd0;
    localparam src_id_t SRC1         = 2'd1;
    localparam src_id_t SRC2         = 2'd2;
    localparam src_id_t RST_LAST_GNT = 2'd2;
    function automatic logic [1:0] sel_of(src_id_t id);
        return {id == SRC2, id == SRC1};
    endfunction
endpackage

// File: rtl/mux3_rr_arbiter_rr_pick3.sv
// rr_pick3: combinational round-robin pick over three requests, order ptr+1, ptr+2, ptr
module rr_pick3
    import mux3_arb_pkg::*;
(
    input  logic [2:0] req,
    input  src_id_t    ptr,
    output logic       win_valid,
    output src_id_t    win_id
);
    src_id_t c1, c2;
    // candidates after the pointer get priority; the pointer itself is last
    always_comb begin
        c1        = (ptr == SRC2) ? SRC0 : ptr + 2'd1;
        c2        = (c1 == SRC2) ? SRC0 : c1 + 2'd1;
        win_valid = |req;
        win_id    = req[c1] ? c1 : (req[c2] ? c2 : ptr);
    end
endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin burst arbiter driving a 3:1 mux into a one-entry output register
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    output logic [2:0]       in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    output logic             sel0,
    output logic             sel1,
    output logic             busy
);
    localparam int CW = $clog2(MAX_BURST + 1);
    arb_state_t       state_q, state_d;
    src_id_t          g_q, g_d, last_gnt_q, last_gnt_d, ptr, win_id, out_src_q, out_src_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             out_valid_q, out_valid_d, win_valid;
    logic [WIDTH-1:0] out_data_q, out_data_d, mux_data;
    logic [1:0]       sel;
    logic             granted, slot_free, accept, decide;

    rr_pick3 u_pick (
        .req      (in_valid),
        .ptr      (ptr),
        .win_valid(win_valid),
        .win_id   (win_id)
    );

    // arbitration decision, handshake and next-state of every register
    always_comb begin
        granted     = state_q == GRANT;
        ptr         = granted ? g_q : last_gnt_q;
        sel         = granted ? sel_of(g_q) : 2'b00;
        mux_data    = sel[1] ? in_data2 : (sel[0] ? in_data1 : in_data0);
        slot_free   = !out_valid_q || out_ready;
        accept      = granted && in_valid[g_q] && slot_free;
        decide      = !granted || !in_valid[g_q] || (accept && beat_cnt_q == CW'(MAX_BURST - 1));
        state_d     = decide ? (win_valid ? GRANT : IDLE) : state_q;
        g_d         = (decide && win_valid) ? win_id : g_q;
        last_gnt_d  = (decide && !win_valid) ? ptr : last_gnt_q;
        beat_cnt_d  = decide ? '0 : beat_cnt_q + CW'(accept);
        out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        out_data_d  = accept ? mux_data : out_data_q;
        out_src_d   = accept ? g_q : out_src_q;
    end

    // state registers; reset drops any held beat and points priority at requester 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            g_q         <= SRC0;
            last_gnt_q  <= RST_LAST_GNT;
            beat_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= SRC0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_gnt_q  <= last_gnt_d;
            beat_cnt_q  <= beat_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign in_ready    = (granted && slot_free) ? (3'b001 << g_q) : 3'b000;
    assign {sel0, sel1} = sel;
    assign busy        = granted;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_src     = out_src_q;
endmodule
